// File: rtl/delay_measure.sv
// rtl/delay_measure.sv - measures the latency of an external delay line in clock cycles
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   start           in   one-cycle request to arm a single measurement (accepted in IDLE only)
//   original_signal in   [WIDTH] signal entering the delay line under test
//   delayed_signal  in   [WIDTH] signal leaving the delay line under test
//   busy            out  high while ARMED or COUNT
//   meas_valid      out  one-cycle pulse, meas_delay holds a fresh result
//   meas_delay      out  [4] measured delay in cycles, held until the next result or timeout
//   timeout         out  one-cycle pulse, no match within MAX_DELAY cycles
//   min_delay       out  [4] smallest result since reset (DELAY_MEASURE_MINMAX_EN only)
//   max_delay       out  [4] largest result since reset (DELAY_MEASURE_MINMAX_EN only)
//
// Optional feature macro: DELAY_MEASURE_MINMAX_EN adds the min_delay/max_delay statistics.

module delay_measure #(
   parameter int WIDTH     = 4,
   parameter int MAX_DELAY = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] original_signal,
   input  logic [WIDTH-1:0] delayed_signal,
   output logic             busy,
   output logic             meas_valid,
   output logic [3:0]       meas_delay,
   output logic             timeout
`ifdef DELAY_MEASURE_MINMAX_EN
   ,
   output logic [3:0]       min_delay,
   output logic [3:0]       max_delay
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_COUNT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] MAX_CNT = 4'(MAX_DELAY);

   logic [1:0]       state_q,   state_d;
   logic [WIDTH-1:0] orig_q;
   logic [WIDTH-1:0] ref_q,     ref_d;
   logic [3:0]       cnt_q,     cnt_d;
   logic [3:0]       delay_q,   delay_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;
   logic             busy_q,    busy_d;

   always_comb begin
      state_d   = state_q;
      ref_d     = ref_q;
      cnt_d     = cnt_q;
      delay_d   = delay_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ARMED;
            end
         end

         ST_ARMED: begin
            // orig_q is last cycle's value, so a difference marks the first
            // edge at which the new value is sampled.
            if (original_signal != orig_q) begin
               ref_d = original_signal;
               cnt_d = 4'd1;
               // A zero-latency line already shows the new value on this edge.
               if (delayed_signal == original_signal) begin
                  delay_d = 4'd0;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_COUNT;
               end
            end
         end

         ST_COUNT: begin
            if (delayed_signal == ref_q) begin
               delay_d = cnt_q;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else if (cnt_q == MAX_CNT) begin
               delay_d   = 4'd0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // busy is registered from the next state so it lines up with the state register.
      busy_d = (state_d == ST_ARMED) || (state_d == ST_COUNT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         orig_q    <= '0;
         ref_q     <= '0;
         cnt_q     <= 4'd0;
         delay_q   <= 4'd0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         orig_q    <= original_signal;
         ref_q     <= ref_d;
         cnt_q     <= cnt_d;
         delay_q   <= delay_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign busy       = busy_q;
   assign meas_valid = valid_q;
   assign meas_delay = delay_q;
   assign timeout    = timeout_q;

`ifdef DELAY_MEASURE_MINMAX_EN
   logic [3:0] min_q, min_d;
   logic [3:0] max_q, max_d;

   // Statistics follow successful results only; timeouts leave them alone.
   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (valid_d) begin
         if (delay_d < min_q) begin
            min_d = delay_d;
         end
         if (delay_d > max_q) begin
            max_d = delay_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= 4'd15;
         max_q <= 4'd0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min_delay = min_q;
   assign max_delay = max_q;
`endif

endmodule

// File: doc/delay_measure.md
DELAY_MEASURE -- requirements
Module: delay_measure

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of both monitored signals.
REQ-002 Parameter: MAX_DELAY, default 15, largest measurable delay in cycles; range 1..15.
REQ-003 The ports SHALL be exactly:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to arm one measurement.
- original_signal  input  WIDTH  signal entering the delay line under test.
- delayed_signal  input  WIDTH  output of the delay line under test.
- busy  output  1  high while armed or counting.
- meas_valid  output  1  one-cycle pulse; meas_delay is valid.
- meas_delay  output  4  measured delay in cycles.
- timeout  output  1  one-cycle pulse; no match within MAX_DELAY.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 The block SHALL implement states IDLE, ARMED, COUNT and DONE.
REQ-006 The block SHALL register orig_q <= original_signal on every edge, including in IDLE.
REQ-007 IDLE: start=1 -> ARMED, busy=1 from the next cycle.
REQ-008 In ARMED, on the edge where original_signal != orig_q, the block SHALL latch ref <= original_signal and set cnt <= 1.
- If delayed_signal == original_signal on that same edge: meas_delay <= 0, go to DONE.
- Otherwise: go to COUNT.
REQ-009 COUNT, on each edge:
- If delayed_signal == ref: meas_delay <= cnt, go to DONE.
- Else if cnt == MAX_DELAY: timeout pulse, meas_delay <= 0, go to IDLE.
- Else: cnt <= cnt + 1.
REQ-010 DONE SHALL last exactly one cycle with meas_valid=1 and busy=0, then return to IDLE.
REQ-011 meas_delay SHALL hold its last value until the next meas_valid or timeout.
REQ-012 Only the first change after arming is measured; changes of original_signal during COUNT or DONE SHALL be ignored.
REQ-013 start while busy=1 or in DONE SHALL be ignored.
REQ-014 meas_valid and timeout SHALL never be high in the same cycle.
REQ-015 cnt SHALL never exceed MAX_DELAY or wrap.

Reset
REQ-016 rst=1 SHALL force IDLE on the next edge, overriding all other inputs, including mid-measurement.
REQ-017 Reset values: busy=0, meas_valid=0, timeout=0, meas_delay=0, cnt=0, ref=0, orig_q=0.
REQ-018 After rst deasserts, a new start SHALL be required to arm.

Configuration
REQ-019 With DELAY_MEASURE_MINMAX_EN defined, the block SHALL add 4-bit output ports min_delay (reset 15) and max_delay (reset 0), updated on each meas_valid as min/max of all results since reset; timeouts do not update them.
REQ-020 Without DELAY_MEASURE_MINMAX_EN, those ports and their registers SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Two-flop delay line, WIDTH=4: start, then original 9->10 -> meas_valid with meas_delay=2, exactly 2 cycles after the change is sampled.
- Combinational passthrough (delayed_signal = original_signal): start, then 11->12 -> meas_valid one cycle later with meas_delay=0.
- delayed_signal tied at 0, MAX_DELAY=15: start, then 12->13 -> timeout pulse 15 cycles after the change, no meas_valid, busy=0.
- 2-cycle line; start, then 9->10, then 10->11 one cycle later -> meas_delay=2 (first change only); start during COUNT has no effect.
- rst asserted while in COUNT at cnt=1 -> next cycle busy=0, meas_valid=0, no pulse afterwards; a fresh start then 5->6 -> meas_delay=2.
- DELAY_MEASURE_MINMAX_EN: measure lines of delay 2, then 5, then 3 -> min_delay=2, max_delay=5; a following timeout leaves both unchanged.
